// File: rtl/seg_scan_ctrl.sv
// seg_scan_ctrl: time-multiplexed scan controller for an 8-digit seven-segment display.
// It produces the digit-mux select, the active-low anodes and the decimal point.
// It also handles per-digit enable masking, 16-level PWM brightness and a frame tick.
`timescale 1ns/1ps
module seg_scan_ctrl #(
    // log2 of clock cycles per digit slot; the PWM compare uses the top 4 bits, so >= 4
    parameter int PRESCALE_LOG2 = 17
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] digit_en,
    input  logic [7:0] dp_in,
    input  logic [3:0] brightness,
    output logic [2:0] sel,
    output logic [7:0] an_n,
    output logic       dp_n,
    output logic       frame_tick
);

    localparam int PW = PRESCALE_LOG2;

    logic [PW-1:0] tick_q, tick_d;
    logic [2:0]    sel_q, sel_d;
    logic [7:0]    an_n_q, an_n_d;
    logic          dp_n_q, dp_n_d;
    logic          frame_tick_q, frame_tick_d;

    logic          boundary;
    logic [7:0]    en_rot;      // en_rot[k] = digit_en[(sel_q + k) mod 8]
    logic [2:0]    step;        // distance from sel_q to the next enabled digit
    logic [7:0]    an_dec;      // active-low one-hot for sel_d
    logic [3:0]    pwm_phase;
    logic          lit;

    // Rotate the enable mask so that bit k describes the digit k places above sel_q.
    // The 3-bit add wraps 7 -> 0 for free.
    for (genvar gi = 0; gi < 8; gi++) begin : g_rot
        assign en_rot[gi] = digit_en[sel_q + 3'(gi)];
    end

    // Active-low one-hot decode of the next select value.
    for (genvar gi = 0; gi < 8; gi++) begin : g_dec
        assign an_dec[gi] = (sel_d != 3'(gi));
    end

    // The last count of a slot is the boundary; the next edge starts a new slot.
    assign boundary = &tick_q;

    // Priority search for the nearest enabled digit above the current one.
    // Offset 8 (which is the current digit itself) is visited first, so it has
    // the lowest priority. It is chosen only when no other digit is enabled.
    always_comb begin
        step = 3'd0;
        for (int k = 8; k >= 1; k--) begin
            if (en_rot[3'(k)]) begin
                step = 3'(k);
            end
        end
    end

    // Next-state for the counter, select and frame tick, plus the registered outputs.
    // The outputs are built from the next-state values, so an_n and dp_n always
    // agree with the sel value that is visible in the same cycle.
    always_comb begin
        tick_d       = tick_q + {{(PW-1){1'b0}}, 1'b1};
        sel_d        = sel_q;
        frame_tick_d = 1'b0;
        if (boundary && (digit_en != 8'h00)) begin
            sel_d        = sel_q + step;
            // Moving to an index no higher than before means the scan wrapped.
            // This includes staying on a lone enabled digit.
            frame_tick_d = (sel_q + step) <= sel_q;
        end

        pwm_phase = tick_d[PW-1 -: 4];
        lit       = digit_en[sel_d] && (pwm_phase <= brightness);
        an_n_d    = lit ? an_dec : 8'hFF;
        dp_n_d    = lit ? ~dp_in[sel_d] : 1'b1;
    end

    // State and output registers with synchronous active-low clear.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            tick_q       <= '0;
            sel_q        <= 3'd0;
            an_n_q       <= 8'hFF;
            dp_n_q       <= 1'b1;
            frame_tick_q <= 1'b0;
        end else begin
            tick_q       <= tick_d;
            sel_q        <= sel_d;
            an_n_q       <= an_n_d;
            dp_n_q       <= dp_n_d;
            frame_tick_q <= frame_tick_d;
        end
    end

    assign sel        = sel_q;
    assign an_n       = an_n_q;
    assign dp_n       = dp_n_q;
    assign frame_tick = frame_tick_q;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// tb_seg_scan_ctrl: directed bench for seg_scan_ctrl with PRESCALE_LOG2=4 (16-cycle slots).
// A slot-level reference model is compared against the DUT on every falling edge.
// Literal expectations at hand-computed cycles pin the model.
`timescale 1ns/1ps
module tb_seg_scan_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] digit_en;
    logic [7:0] dp_in;
    logic [3:0] brightness;
    logic [2:0] sel;
    logic [7:0] an_n;
    logic       dp_n;
    logic       frame_tick;

    int total = 0;
    int bad   = 0;

    seg_scan_ctrl #(.PRESCALE_LOG2(4)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .digit_en   (digit_en),
        .dp_in      (dp_in),
        .brightness (brightness),
        .sel        (sel),
        .an_n       (an_n),
        .dp_n       (dp_n),
        .frame_tick (frame_tick)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model, kept in whole numbers:
    // - slot position m_tick 0..15, and m_sel is the digit being shown;
    // - at the last count of a slot, the scan moves to the first enabled digit found
    //   walking upward modulo 8;
    // - the display is lit while the slot position is no greater than brightness.
    int   m_tick, m_sel;
    logic [7:0] m_an;
    logic m_dp, m_ft;
    bit   m_valid = 0;

    always @(posedge clk) begin
        int nt, ns;
        bit bnd, lit;
        if (!rst_n) begin
            m_tick = 0; m_sel = 0; m_an = 8'hFF; m_dp = 1'b1; m_ft = 1'b0;
            m_valid = 1;
        end else if (m_valid) begin
            bnd = (m_tick == 15);
            nt  = (m_tick + 1) % 16;
            ns  = m_sel;
            if (bnd && digit_en != 8'h00) begin
                for (int k = 1; k <= 8; k++) begin
                    if (digit_en[(m_sel + k) % 8]) begin
                        ns = (m_sel + k) % 8;
                        break;
                    end
                end
            end
            m_ft   = bnd && (digit_en != 8'h00) && (ns <= m_sel);
            lit    = digit_en[ns] && (nt <= int'(brightness));
            m_an   = lit ? (8'hFF ^ (8'h01 << ns)) : 8'hFF;
            m_dp   = lit ? ~dp_in[ns] : 1'b1;
            m_tick = nt;
            m_sel  = ns;
        end
    end

    // Compare the DUT against the model on every falling edge after the first reset.
    always @(negedge clk) begin
        if (m_valid) begin
            check("model_sel",  {5'd0, sel},        8'(m_sel));
            check("model_an_n", an_n,               m_an);
            check("model_dp_n", {7'd0, dp_n},       {7'd0, m_dp});
            check("model_tick", {7'd0, frame_tick}, {7'd0, m_ft});
        end
    end

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Directed sequence. Inputs change on falling edges. k below counts falling
    // edges after reset release; the slot position at edge k is k mod 16.
    initial begin
        rst_n = 1'b0; digit_en = 8'hFF; dp_in = 8'h00; brightness = 4'd15;
        step(3);
        check("rst_sel",  {5'd0, sel}, 8'h00);
        check("rst_an",   an_n, 8'hFF);
        check("rst_dp",   {7'd0, dp_n}, 8'h01);
        check("rst_ft",   {7'd0, frame_tick}, 8'h00);
        rst_n = 1'b1;
        step(1);                                       // k=1
        check("first_an", an_n, 8'hFE);
        step(15);                                      // k=16
        check("scan_sel1", {5'd0, sel}, 8'h01);
        check("scan_an1",  an_n, 8'hFD);
        step(111);                                     // k=127
        check("scan_sel7", {5'd0, sel}, 8'h07);
        check("scan_an7",  an_n, 8'h7F);
        check("scan_noft", {7'd0, frame_tick}, 8'h00);
        step(1);                                       // k=128
        check("wrap_sel",  {5'd0, sel}, 8'h00);
        check("wrap_ft",   {7'd0, frame_tick}, 8'h01);
        // decimal points on digits 0 and 2
        dp_in = 8'h05;
        step(1);                                       // k=129
        check("dp_d0", {7'd0, dp_n}, 8'h00);
        step(15);                                      // k=144
        check("dp_d1", {7'd0, dp_n}, 8'h01);
        step(16);                                      // k=160
        check("dp_d2", {7'd0, dp_n}, 8'h00);
        dp_in = 8'h00;
        // brightness 3: lit for slot positions 0..3
        brightness = 4'd3;
        step(3);                                       // k=163
        check("bri3_on",  an_n, 8'hFB);
        step(1);                                       // k=164
        check("bri3_off", an_n, 8'hFF);
        brightness = 4'd0;
        step(12);                                      // k=176, sel 3
        check("bri0_on",  an_n, 8'hF7);
        step(1);                                       // k=177
        check("bri0_off", an_n, 8'hFF);
        brightness = 4'd15;
        // mask skip 2<->5. Digit 3 is masked live, so it blanks next cycle.
        digit_en = 8'b0010_0100;
        step(1);                                       // k=178
        check("mask_blank", an_n, 8'hFF);
        check("mask_hold",  {5'd0, sel}, 8'h03);
        step(14);                                      // k=192
        check("skip_sel5", {5'd0, sel}, 8'h05);
        check("skip_an5",  an_n, 8'hDF);
        check("skip_ft0",  {7'd0, frame_tick}, 8'h00);
        step(16);                                      // k=208
        check("skip_sel2", {5'd0, sel}, 8'h02);
        check("skip_an2",  an_n, 8'hFB);
        check("skip_ft1",  {7'd0, frame_tick}, 8'h01);
        step(32);                                      // k=240
        // empty mask: dark, frozen, no tick
        digit_en = 8'h00;
        step(16);                                      // k=256
        check("zero_sel", {5'd0, sel}, 8'h02);
        check("zero_an",  an_n, 8'hFF);
        check("zero_ft",  {7'd0, frame_tick}, 8'h00);
        digit_en = 8'h80;
        step(16);                                      // k=272
        check("only7_sel", {5'd0, sel}, 8'h07);
        check("only7_an",  an_n, 8'h7F);
        // clear the shown digit mid-slot
        digit_en = 8'hFF;
        step(1);                                       // k=273
        digit_en = 8'h7F;
        step(1);                                       // k=274
        check("clr_an",  an_n, 8'hFF);
        check("clr_sel", {5'd0, sel}, 8'h07);
        step(14);                                      // k=288
        check("clr_next", {5'd0, sel}, 8'h00);
        check("clr_ft",   {7'd0, frame_tick}, 8'h01);
        digit_en = 8'hFF;
        step(89);                                      // k=377: sel 5, position 9
        check("pre_rst_sel", {5'd0, sel}, 8'h05);
        check("pre_rst_an",  an_n, 8'hDF);
        rst_n = 1'b0;
        step(1);
        check("mid_rst_sel", {5'd0, sel}, 8'h00);
        check("mid_rst_an",  an_n, 8'hFF);
        rst_n = 1'b1;
        step(1);
        check("rerun_an", an_n, 8'hFE);
        step(15);
        check("rerun_sel1", {5'd0, sel}, 8'h01);
        // single enabled digit: tick every slot
        digit_en = 8'h08;
        step(16);
        check("solo_sel", {5'd0, sel}, 8'h03);
        step(16);
        check("solo_ft",  {7'd0, frame_tick}, 8'h01);
        step(2);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/seg_scan_ctrl.md
Name: seg_scan_ctrl

Overview:
Time-multiplexing controller for the 8-digit seven-segment display. It generates the 3-bit digit select that drives the 8:1 nibble mux, and the matching active-low anode vector and decimal point. It also adds per-digit enable masking, 16-level PWM brightness and a once-per-frame tick. It sits between the top-level display registers and the digit mux / hex-to-segment decoder.

Parameters:
PRESCALE_LOG2, 17, log2 of clock cycles per digit slot; must be at least 4. 2^17 at 100 MHz gives 1.31 ms per slot, about 95 Hz frame rate with 8 digits.

Ports:
clk  input  1  system clock
rst_n  input  1  synchronous reset, active-low
digit_en  input  8  per-digit enable mask; bit i enables digit i
dp_in  input  8  per-digit decimal point request, active-high
brightness  input  4  PWM duty level; 0 = 1/16 duty, 15 = full on
sel  output  3  digit index for the digit mux select
an_n  output  8  anode drive, active-low, one-hot-low when lit
dp_n  output  1  decimal point drive, active-low
frame_tick  output  1  one-cycle pulse at each scan wrap

Behaviour:
- One clock; reset is synchronous and active-low: while rst_n=0 at a clk edge, all state clears.
- Reset values: tick_cnt=0, sel=0, an_n=8'hFF, dp_n=1, frame_tick=0.
- tick_cnt is a PRESCALE_LOG2-bit free-running counter. The cycle where tick_cnt wraps from all-ones to 0 is the slot boundary.
- Digit advance at a slot boundary:
  - sel becomes the next index above the current one, searching upward with wrap-around 7→0, whose digit_en bit is 1. Use a priority search over the 8 bits.
  - If no other bit is set but the current digit is enabled, sel stays.
  - If digit_en==0, sel holds its value.
  - digit_en is sampled only at boundaries for this advance decision.
- Anode lit condition: digit_en[sel]=1 (live mask, not sampled) AND tick_cnt[PRESCALE_LOG2-1 -: 4] <= brightness.
  - When lit: an_n = ~(8'b1 << sel).
  - Otherwise: an_n = 8'hFF.
  - Clearing the current digit's enable therefore blanks it in the very next cycle.
- dp_n = ~dp_in[sel] when lit, else 1.
- an_n and dp_n are registered and computed from the next-state sel/tick_cnt. sel, an_n and dp_n therefore change on the same edge and are always mutually consistent. No cycle may show an_n lighting a digit other than sel.
- frame_tick = 1 for exactly the one cycle following a boundary at which sel moved to a value ≤ its previous value (scan wrap).
  - With exactly one enabled digit, it pulses every slot.
  - With digit_en==0, it never pulses.
- After reset release with digit_en[0]=0, sel stays 0 and the display stays dark until the first boundary, which moves sel to the lowest enabled digit.
- brightness is sampled live every cycle; changing it mid-slot alters the duty of the current slot immediately.
- Reset mid-scan returns all state to reset values in the cycle after the asserted edge, whatever the slot phase.
- Outputs never contain X after reset for any input combination.

Test Plan:
- Reset: PRESCALE_LOG2=4, digit_en=FF, brightness=15, hold rst_n=0 for 3 cycles → sel=0, an_n=FF, dp_n=1, frame_tick=0. First cycle after release → an_n=FE.
- Full scan: digit_en=FF, brightness=15 → sel steps 0..7 every 16 cycles with an_n FE,FD,FB,...,7F. frame_tick asserts once per 128 cycles, in the cycle sel goes 7→0.
- Mask skip: digit_en=8'b0010_0100 → sel alternates 2,5 every 16 cycles with an_n FB/DF. frame_tick every 32 cycles at the 5→2 transition. All-zero mask → an_n=FF, sel frozen, no frame_tick. Then set 8'h80 → at the next boundary sel=7 and an_n=7F.
- Brightness: brightness=3 → each slot lights for tick_cnt 0..3 (4 of 16 cycles) and is FF otherwise. brightness=0 → 1 cycle of 16.
- Decimal point: dp_in=8'h05, all enabled, brightness=15 → dp_n=0 only while sel=0 or sel=2, and 1 in the other slots.
- Mid-operation events: clear digit_en[sel] mid-slot → an_n=FF on the next cycle, sel unchanged until the boundary. Assert rst_n=0 at tick_cnt=9, sel=5 → next cycle sel=0, an_n=FF, tick_cnt=0.
